// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT data loader: FSM state encoding, default widths.
// No logic; the counter width helper keeps every sample counter sized to exactly $clog2(N).
// Imported by fft_data_loader and fft_dl_skid_buffer.
package fft_pkg;

   localparam int FFT_DATA_WIDTH = 32;
   localparam int FFT_N_DEFAULT  = 1024;
   localparam int FFT_CNT_W      = $clog2(FFT_N_DEFAULT);

   typedef enum logic [2:0] {
      DL_IDLE,
      DL_START,
      DL_LOAD,
      DL_DRAIN,
      DL_WAIT
   } dl_state_t;

   function automatic int dl_cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fft_dl_skid_buffer.sv
// Two-entry skid buffer between the upstream sample port and the FFT input.
// Latency: 1 cycle push-to-head when empty. Backpressure: in_rdy is a flop, low only when both entries are full.
// in_rdy_nxt exposes next cycle's ready so the parent can register its own accept signal from it.
module fft_dl_skid_buffer
   import fft_pkg::*;
#(
   parameter int W = 2 * FFT_DATA_WIDTH + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   output logic         in_rdy,
   output logic         in_rdy_nxt,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat
);

   logic [1:0]   cnt;
   logic [1:0]   cnt_nxt;
   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic         push;
   logic         pop;

   assign push       = in_vld & in_rdy;
   assign pop        = out_vld & out_rdy;
   assign out_vld    = (cnt != 2'd0);
   assign out_dat    = head;
   assign in_rdy_nxt = (cnt_nxt != 2'd2);

   always_comb begin
      cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
   end

   // head keeps its last value when the buffer empties, so the consumer sees stable data while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= 2'd0;
         in_rdy <= 1'b1;
         head   <= '0;
         tail   <= '0;
      end else begin
         cnt    <= cnt_nxt;
         in_rdy <= in_rdy_nxt;
         if (pop && (cnt == 2'd2))
            head <= tail;
         else if (push && ((cnt == 2'd0) || ((cnt == 2'd1) && pop)))
            head <= in_dat;
         if (push && (cnt == 2'd1) && !pop)
            tail <= in_dat;
      end
   end

endmodule

// File: rtl/fft_data_loader.sv
// Loads one N-sample frame from a valid/ready stream into the FFT core, pulsing start_o first.
// Latency: 1 cycle accept-to-dready_o via the skid; s_ready_o is registered and drops after the N-th accept.
// Optional FFT_DL_LAST_CHECK_EN: sticky err_o when s_last_i disagrees with the frame position.
module fft_data_loader
   import fft_pkg::*;
#(
   parameter int N          = FFT_N_DEFAULT,
   parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_re_i,
   input  logic [DATA_WIDTH-1:0] s_im_i,
   input  logic                  s_last_i,
   input  logic                  fft_busy_i,
   input  logic                  fft_done_i,
   output logic                  start_o,
   output logic                  dready_o,
   output logic [DATA_WIDTH-1:0] x0_re_o,
   output logic [DATA_WIDTH-1:0] x0_im_o,
   output logic                  dl_busy_o,
   output logic                  err_o
);

   localparam int              CW       = dl_cnt_width(N);
   localparam int              SW       = 2 * DATA_WIDTH + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

   dl_state_t     state;
   logic [CW-1:0] acc_cnt;
   logic [CW-1:0] iss_cnt;
   logic          iss_all;
   logic          fire;

   logic          skid_in_rdy;
   logic          skid_rdy_nxt;
   logic          skid_out_vld;
   logic [SW-1:0] skid_out_dat;
   logic          unused_skid;

   assign fire        = s_valid_i & s_ready_o;
   assign dready_o    = skid_out_vld;
   assign x0_re_o     = skid_out_dat[2*DATA_WIDTH-1:DATA_WIDTH];
   assign x0_im_o     = skid_out_dat[DATA_WIDTH-1:0];
   // s_ready_o already tracks skid room, so the skid's own ready and the carried last flag are not consulted here
   assign unused_skid = skid_in_rdy ^ skid_out_dat[SW-1];

   fft_dl_skid_buffer #(
      .W (SW)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .in_vld     (fire),
      .in_rdy     (skid_in_rdy),
      .in_rdy_nxt (skid_rdy_nxt),
      .in_dat     ({s_last_i, s_re_i, s_im_i}),
      .out_vld    (skid_out_vld),
      .out_rdy    (1'b1),
      .out_dat    (skid_out_dat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DL_IDLE;
         acc_cnt   <= '0;
         iss_cnt   <= '0;
         iss_all   <= 1'b0;
         s_ready_o <= 1'b0;
         start_o   <= 1'b0;
         dl_busy_o <= 1'b0;
      end else begin
         start_o <= 1'b0;

         if (dready_o) begin
            if (iss_cnt == CNT_LAST) begin
               iss_cnt <= '0;
               iss_all <= 1'b1;
            end else begin
               iss_cnt <= iss_cnt + CW'(1);
            end
         end

         case (state)
            DL_IDLE: begin
               if (s_valid_i && !fft_busy_i) begin
                  state     <= DL_START;
                  start_o   <= 1'b1;
                  dl_busy_o <= 1'b1;
               end
            end
            DL_START: begin
               state     <= DL_LOAD;
               s_ready_o <= skid_rdy_nxt;
            end
            DL_LOAD: begin
               s_ready_o <= skid_rdy_nxt;
               if (fire) begin
                  if (acc_cnt == CNT_LAST) begin
                     acc_cnt   <= '0;
                     s_ready_o <= 1'b0;
                     state     <= DL_DRAIN;
                  end else begin
                     acc_cnt <= acc_cnt + CW'(1);
                  end
               end
            end
            DL_DRAIN: begin
               if (!skid_out_vld && iss_all) begin
                  state     <= DL_WAIT;
                  dl_busy_o <= 1'b0;
                  iss_all   <= 1'b0;
               end
            end
            DL_WAIT: begin
               if (fft_done_i)
                  state <= DL_IDLE;
            end
            default: begin
               state     <= DL_IDLE;
               s_ready_o <= 1'b0;
               dl_busy_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef FFT_DL_LAST_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_o <= 1'b0;
      else if (fire && (s_last_i != (acc_cnt == CNT_LAST)))
         err_o <= 1'b1;
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft_data_loader.sv
// Randomised bench for fft_data_loader (N=8): a queue of accepted samples is the reference for
// the issued stream; frame-level rules (start pulses, issue counts, WAIT/IDLE, err) are tracked separately.
module tb_fft_data_loader;

   localparam int N  = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid_i = 1'b0;
   logic          s_last_i = 1'b0;
   logic          fft_busy_i = 1'b0;
   logic          fft_done_i = 1'b0;
   logic [DW-1:0] s_re_i = '0;
   logic [DW-1:0] s_im_i = '0;
   logic          s_ready_o, start_o, dready_o, dl_busy_o, err_o;
   logic [DW-1:0] x0_re_o, x0_im_o;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [2*DW-1:0] exp_q[$];
   logic [2*DW-1:0] last_x0 = '0;
   int            issued = 0;
   int            starts = 0;
   int            exp_starts = 0;
   int            dr_run = 0;
   int            dr_max = 0;
   bit            mon_en = 1'b0;
   bit            exp_err = 1'b0;

   always #5 clk = ~clk;

   fft_data_loader #(
      .N          (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid_i  (s_valid_i),
      .s_ready_o  (s_ready_o),
      .s_re_i     (s_re_i),
      .s_im_i     (s_im_i),
      .s_last_i   (s_last_i),
      .fft_busy_i (fft_busy_i),
      .fft_done_i (fft_done_i),
      .start_o    (start_o),
      .dready_o   (dready_o),
      .x0_re_o    (x0_re_o),
      .x0_im_o    (x0_im_o),
      .dl_busy_o  (dl_busy_o),
      .err_o      (err_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every issued sample must be the oldest accepted one; idle cycles must hold x0
   always @(negedge clk) begin
      if (mon_en) begin
         if (dready_o) begin
            dr_run++;
            if (dr_run > dr_max) dr_max = dr_run;
            issued++;
            if (exp_q.size() == 0)
               check("spurious_issue", 64'd1, 64'd0);
            else
               check("issue_data", {x0_re_o, x0_im_o}, exp_q.pop_front());
         end else begin
            dr_run = 0;
            check("x0_hold", {x0_re_o, x0_im_o}, last_x0);
         end
         last_x0 = {x0_re_o, x0_im_o};
         if (start_o) starts++;
         if (rst) begin
            exp_q.delete();
            last_x0 = '0;
         end else if (s_valid_i && s_ready_o) begin
            exp_q.push_back({s_re_i, s_im_i});
         end
      end
   end

   // pat: 0 continuous valid, 1 toggling valid, 2 random valid
   task automatic send_frame(input int pat, input int last_at, input int stop_at, input int done_at);
      int sent = 0;
      int cyc  = 0;
      bit acc;
      s_valid_i = (pat == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_re_i    = '0;
      s_im_i    = DW'($urandom);
      s_last_i  = (last_at == 0);
      while (sent < stop_at && cyc < 200) begin
         @(negedge clk);
         acc = s_valid_i && s_ready_o;
         if (acc) begin
`ifdef FFT_DL_LAST_CHECK_EN
            if (s_last_i != (sent == N - 1)) exp_err = 1'b1;
`endif
            sent++;
         end
         tick();
         cyc++;
         fft_done_i = (cyc == done_at);
         case (pat)
            0:       s_valid_i = 1'b1;
            1:       s_valid_i = (cyc % 2 == 0);
            default: s_valid_i = 1'($urandom_range(0, 1));
         endcase
         if (acc) begin
            s_re_i   = DW'(sent);
            s_im_i   = DW'($urandom);
            s_last_i = (sent == last_at);
         end
      end
      s_valid_i  = 1'b0;
      s_last_i   = 1'b0;
      fft_done_i = 1'b0;
      check("send_in_time", 64'(cyc < 200), 64'd1);
   endtask

   task automatic finish_frame(input bit restart, input bit chk_run);
      int cyc = 0;
      while ((dl_busy_o || exp_q.size() != 0) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("drain_in_time", 64'(cyc < 100), 64'd1);
      check("issued_count", 64'(issued), 64'(N));
      check("s_ready_in_wait", 64'(s_ready_o), 64'd0);
      check("err_flag", 64'(err_o), 64'(exp_err));
      if (chk_run) check("consecutive_dready", 64'(dr_max), 64'(N));
      s_valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("no_start_in_wait", 64'(start_o), 64'd0);
         check("dl_busy_in_wait", 64'(dl_busy_o), 64'd0);
      end
      s_valid_i  = restart;
      fft_done_i = 1'b1;
      tick();
      fft_done_i = 1'b0;
      issued = 0;
      dr_max = 0;
      @(negedge clk);
      check("start_after_done_edge", 64'(start_o), 64'd0);
      if (restart) begin
         @(negedge clk);
         check("start_after_done", 64'(start_o), 64'd1);
         exp_starts++;
      end
      tick();
   endtask

   task automatic check_outputs_reset();
      check("rst_s_ready", 64'(s_ready_o), 64'd0);
      check("rst_start", 64'(start_o), 64'd0);
      check("rst_dready", 64'(dready_o), 64'd0);
      check("rst_x0", {x0_re_o, x0_im_o}, 64'd0);
      check("rst_dl_busy", 64'(dl_busy_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
   endtask

   initial begin
      repeat (2) tick();
      check_outputs_reset();
      rst = 1'b0;
      mon_en = 1'b1;

      // continuous frame, then fft_done restarts straight into the next frame
      exp_starts++;
      send_frame(0, N - 1, N, 0);
      finish_frame(1'b1, 1'b1);
      send_frame(1, N - 1, N, 0);
      finish_frame(1'b0, 1'b0);

      // core busy: no start, no ready; start one cycle after busy falls
      fft_busy_i = 1'b1;
      s_valid_i  = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("busy_no_start", 64'(start_o), 64'd0);
         check("busy_no_ready", 64'(s_ready_o), 64'd0);
      end
      tick();
      fft_busy_i = 1'b0;
      @(negedge clk);
      check("busy_fall_edge", 64'(start_o), 64'd0);
      @(negedge clk);
      check("start_after_busy", 64'(start_o), 64'd1);
      exp_starts++;
      tick();
      send_frame(2, N - 1, N, 3);
      finish_frame(1'b0, 1'b0);

      // reset mid-frame after four samples
      exp_starts++;
      send_frame(0, N - 1, 4, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_outputs_reset();
      issued  = 0;
      dr_max  = 0;
      exp_err = 1'b0;
      tick();

      exp_starts++;
      send_frame(2, N - 1, N, 0);
      finish_frame(1'b0, 1'b0);

      // misplaced last flag, then a clean frame to show the error is sticky
      exp_starts++;
      send_frame(0, 4, N, 0);
      finish_frame(1'b0, 1'b0);
      exp_starts++;
      send_frame(1, N - 1, N, 0);
      finish_frame(1'b0, 1'b0);

      check("start_pulses", 64'(starts), 64'(exp_starts));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fft_data_loader.md
FFT_DATA_LOADER -- requirements
Module: fft_data_loader

Interface
REQ-001 SHALL have parameter N, default 1024: samples per frame, power of two, 8..4096.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of each real and imaginary word.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid_i  input  1  upstream sample valid.
REQ-006 SHALL have port s_ready_o  output  1  upstream sample accept.
REQ-007 SHALL have port s_re_i / s_im_i  input  DATA_WIDTH each  upstream sample.
REQ-008 SHALL have port s_last_i  input  1  upstream marks the final sample of a frame.
REQ-009 SHALL have port fft_busy_i  input  1  FFT core busy.
REQ-010 SHALL have port fft_done_i  input  1  FFT core one-cycle frame-complete pulse.
REQ-011 SHALL have port start_o  output  1  one-cycle FFT start pulse.
REQ-012 SHALL have port dready_o  output  1  x0_re_o/x0_im_o valid this cycle.
REQ-013 SHALL have port x0_re_o / x0_im_o  output  DATA_WIDTH each  sample to the FFT.
REQ-014 SHALL have port dl_busy_o  output  1  loader owns the FFT input port.
REQ-015 SHALL have port err_o  output  1  sticky framing error.

Function
REQ-016 SHALL implement FSM states IDLE, START, LOAD, DRAIN, WAIT.
REQ-017 SHALL move IDLE->START when s_valid_i=1 and fft_busy_i=0.
REQ-018 SHALL hold IDLE while fft_busy_i=1, even with s_valid_i=1.
REQ-019 SHALL stay in START for exactly one cycle with start_o=1, then enter LOAD.
REQ-020 SHALL accept upstream samples only in LOAD, through the skid buffer; s_ready_o is registered and equals "skid not full and accepted count < N".
REQ-021 SHALL issue at most one sample per cycle to the FFT: dready_o=1 with x0_re_o/x0_im_o driven from the skid head; latency from acceptance to dready_o is 1 cycle when the skid is empty.
REQ-022 SHALL count accepted samples 0..N-1; on the N-th acceptance it SHALL drop s_ready_o in the next cycle and enter DRAIN.
REQ-023 SHALL stay in DRAIN until the skid is empty and N samples have been issued, then enter WAIT.
REQ-024 SHALL leave WAIT for IDLE on fft_done_i=1.
REQ-025 SHALL ignore fft_done_i in any state other than WAIT.
REQ-026 SHALL drive dl_busy_o=1 in START, LOAD and DRAIN, and 0 otherwise.
REQ-027 SHALL hold x0_re_o/x0_im_o at their last value while dready_o=0.
REQ-028 SHALL allow an upstream stall (s_valid_i=0) mid-frame with no sample loss or duplication.
REQ-029 SHALL let the issued-sample counter wrap to 0 at frame end.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE from any state (including mid-frame), flush the skid, and clear both counters.
REQ-031 SHALL reset outputs to: s_ready_o=0, start_o=0, dready_o=0, x0_re_o=0, x0_im_o=0, dl_busy_o=0, err_o=0.

Configuration
REQ-032 SHALL, with FFT_DL_LAST_CHECK_EN defined, set err_o=1 when s_last_i=1 on an acceptance with count != N-1, or when s_last_i=0 on acceptance N-1; err_o is sticky until rst and does not alter the frame flow.
REQ-033 SHALL, without FFT_DL_LAST_CHECK_EN, ignore s_last_i and tie err_o to 0.

Structure
REQ-034 SHALL place the FSM state enum, the counter width constant $clog2(N) and the DATA_WIDTH default in shared package fft_pkg.
REQ-035 SHALL instantiate exactly one sub-module, fft_dl_skid_buffer: 2-entry, registered ready, width 2*DATA_WIDTH+1.

Verification
REQ-036 SHALL verify: N=8, continuous s_valid_i, fft_busy_i=0 -> one start_o pulse, then 8 consecutive dready_o cycles with data 0..7 in order, dl_busy_o falls, FSM in WAIT.
REQ-037 SHALL verify: s_valid_i toggled 1,0,1,0 during LOAD -> all 8 samples issued exactly once, in order.
REQ-038 SHALL verify: fft_busy_i=1 with s_valid_i=1 for 20 cycles -> start_o=0, s_ready_o=0; after fft_busy_i falls, start_o pulses 1 cycle later.
REQ-039 SHALL verify: rst asserted after sample 4 of 8 -> all outputs reset next cycle; the next frame starts fresh with count 0.
REQ-040 SHALL verify, with FFT_DL_LAST_CHECK_EN: s_last_i=1 on sample 5 -> err_o=1 and stays 1; 8 samples still issued; without the macro err_o stays 0.
REQ-041 SHALL verify: fft_done_i pulsed during LOAD -> ignored; pulsed in WAIT -> IDLE next cycle.
